mem_channel_responder: RTL and testbench
========================================

// Module: mem_channel_responder
// PURPOSE
// - Memory-side responder for the multi-channel memory controller protocol. It serves
//   NUM_CHANNELS read/write channels from one single-ported storage array.
// - Per channel: holds the valid/ready handshake, models fixed access LATENCY, and
//   arbitrates storage round-robin.
// - Used as the program or data memory behind the memory controller, in simulation
//   and in FPGA builds.
// PARAMETERS
// - ADDR_BITS     8   address width; storage depth = 2**ADDR_BITS words
// - DATA_BITS     16  word width (8 for data memory, 16 for program memory)
// - NUM_CHANNELS  4   number of controller channels served
// - LATENCY       2   cycles from storage grant to ready (>=1)
// - WRITE_ENABLE  1   0: write channels tie write_ready low and never write (program memory)
// PORTS
// - clk                input   1                  clock
// - reset              input   1                  synchronous, active-high
// - mem_read_valid     input   NUM_CHANNELS       per-channel read request
// - mem_read_address   input   ADDR_BITS x NCH    read address; held while valid
// - mem_read_ready     output  NUM_CHANNELS       one-cycle read completion pulse
// - mem_read_data      output  DATA_BITS x NCH    read word; valid while ready=1
// - mem_write_valid    input   NUM_CHANNELS       per-channel write request
// - mem_write_address  input   ADDR_BITS x NCH    write address; held while valid
// - mem_write_data     input   DATA_BITS x NCH    write word; held while valid
// - mem_write_ready    output  NUM_CHANNELS       one-cycle write completion pulse
// - load_valid         input   1                  host preload strobe
// - load_address       input   ADDR_BITS          preload address
// - load_data          input   DATA_BITS          preload word
// BEHAVIOUR
// - Clocking: clk, synchronous active-high reset. All outputs are registered.
// - Reset values: ready=0 on every channel; read data=0; all channel FSMs go to IDLE;
//   the round-robin pointer goes to 0. Storage contents are NOT reset.
// - Per-channel FSM: IDLE -> ACCESS -> DELAY -> RESP -> DRAIN -> IDLE.
//   - IDLE: read_valid or write_valid high -> request the arbiter in the same cycle.
//     Read wins if both are high. Latch the op type and address/data.
//   - ACCESS: request held until granted. On the grant edge, a read captures storage
//     and a write commits storage. The channel's latency counter then loads LATENCY-1.
//   - DELAY: count down to 0. With LATENCY=1 the channel goes straight to RESP.
//   - RESP: the matching ready is high for exactly one cycle, with read_data stable.
//   - DRAIN: wait until the corresponding valid is sampled low, then go to IDLE.
//     This prevents a stale valid from re-issuing the request.
// - Uncontended latency: valid first sampled at edge E0 -> ready high after edge
//   E0+LATENCY. Each earlier-granted competitor adds 1 cycle.
// - Arbitration: one storage access per cycle.
//   - Grant order is round-robin starting at the pointer.
//   - Pointer = granted index+1, wrapping NUM_CHANNELS-1 -> 0.
//   - load_valid has absolute priority: no channel grant in that cycle, and the load
//     writes storage at that edge.
// - Same-address events: a write granted at edge E is visible to a read granted at
//   E+1 or later. Load then channel write to the same address in consecutive cycles:
//   the later one wins.
// - WRITE_ENABLE=0: write requests are ignored. write_ready stays 0 and the channel
//   stays IDLE.
// - Reset mid-operation: pending requests are dropped and no ready is issued. Writes
//   already granted remain committed.
// - Out-of-range addresses are impossible: the address is exactly ADDR_BITS wide.
// STRUCTURE
// - Shared package gpu_mem_pkg: resp_state_t enum (IDLE/ACCESS/DELAY/RESP/DRAIN) and
//   op_t enum (OP_READ/OP_WRITE).
// - Sub-module rr_arbiter #(N): request vector in, one-hot grant plus index out, and an
//   advance enable for the pointer update.
// - Per-channel FSM and counters are generated in a for-generate loop.
// - Storage is an inferred single-port array; the write port is muxed between load
//   and the granted channel.
// TESTING
// - Preload addr 0x10=0xBEEF; ch0 read 0x10 -> read_ready[0] pulses 1 cycle after
//   E0+2 with data 0xBEEF.
// - ch0..ch3 read simultaneously (LATENCY=2) -> ready pulses at E0+2, E0+3, E0+4, E0+5,
//   in order ch0..ch3. Next round starts from the pointer.
// - ch1 write 0x20=0x1234 and ch2 read 0x20 one cycle later -> ch2 returns 0x1234.
//   Each ready is a single cycle.
// - Hold ch0 read_valid 3 cycles after ready -> exactly one ready pulse, FSM stays in
//   DRAIN, and the new request is accepted only after valid is seen low.
// - load_valid held for 4 cycles while ch0 reads -> ch0 ready is delayed 4 cycles and
//   the data reflects any load to the same address.
// - Assert reset during ch3 DELAY -> no ready after reset; all ready=0 and data=0.
//   Preloaded contents survive the reset.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types for the memory-channel responder.
//   resp_state_t : per-channel responder FSM state
//   op_t         : operation type a channel has latched
package gpu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    DELAY  = 3'd2,
    RESP   = 3'd3,
    DRAIN  = 3'd4
  } resp_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage : gpu_mem_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (pointer -> 0)
//   req         : request vector, one bit per requester
//   advance     : when high and a grant is issued, pointer moves past the winner
//   grant       : one-hot grant
//   grant_idx   : binary index of the granted requester
//   grant_valid : a grant is issued this cycle
// The search starts at the pointer and wraps, so the requester just served has
// the lowest priority on the next cycle.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < N; off++) begin
      int cand;
      cand = (int'(ptr_q) + off) % N;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;

    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule : rr_arbiter

// File: rtl/mem_channel_responder.sv
// Memory-side responder serving NUM_CHANNELS read/write channels from one
// single-ported storage array with a fixed access latency.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   mem_read_valid     : per-channel read request (address held while high)
//   mem_read_address   : per-channel read address
//   mem_read_ready     : per-channel one-cycle read completion pulse
//   mem_read_data      : per-channel read word, valid while ready is high
//   mem_write_valid    : per-channel write request (address/data held while high)
//   mem_write_address  : per-channel write address
//   mem_write_data     : per-channel write word
//   mem_write_ready    : per-channel one-cycle write completion pulse
//   load_valid         : host preload strobe, wins over every channel
//   load_address       : preload address
//   load_data          : preload word
// Each channel runs IDLE -> ACCESS -> DELAY -> RESP -> DRAIN -> IDLE. A channel
// in IDLE requests storage in the same cycle it sees valid, so an uncontended
// access is granted on the first edge that samples valid.
module mem_channel_responder
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CHANNELS-1:0]               mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]               mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]               mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]               mem_write_ready,
  input  logic                                  load_valid,
  input  logic [ADDR_BITS-1:0]                  load_address,
  input  logic [DATA_BITS-1:0]                  load_data
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam int DEPTH = 2 ** ADDR_BITS;

  // Per-channel view of the access it wants: straight from the ports while
  // IDLE (so the first cycle can already be granted), latched afterwards.
  logic [NUM_CHANNELS-1:0] chan_req;
  op_t                     chan_op    [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    chan_addr  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    chan_wdata [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] arb_req;
  logic [NUM_CHANNELS-1:0] grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_valid;

  logic [ADDR_BITS-1:0]    acc_addr;
  logic [DATA_BITS-1:0]    mem_rdata;
  logic                    mem_we;
  logic [ADDR_BITS-1:0]    mem_waddr;
  logic [DATA_BITS-1:0]    mem_wdata;

  logic [DATA_BITS-1:0]    mem_q [DEPTH];

  // A load owns the storage port for its cycle; channels simply wait. Requests
  // are also masked during reset so nothing is granted on a reset edge.
  assign arb_req = (reset || load_valid) ? '0 : chan_req;

  rr_arbiter #(
    .N     (NUM_CHANNELS),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (arb_req),
    .advance     (!load_valid),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign acc_addr  = chan_addr[grant_idx];
  assign mem_rdata = mem_q[acc_addr];

  // Single write port: load first, otherwise the granted channel if it writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = load_address;
    mem_wdata = load_data;
    if (load_valid) begin
      mem_we = 1'b1;
    end else if (grant_valid && chan_op[grant_idx] == OP_WRITE) begin
      mem_we    = 1'b1;
      mem_waddr = acc_addr;
      mem_wdata = chan_wdata[grant_idx];
    end
  end

  // NOTE: the storage array has no reset on purpose: contents must survive a
  // reset, and a resettable array could not map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    resp_state_t          state_q, state_d;
    op_t                  op_q, op_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rready_q, rready_d;
    logic                 wready_q, wready_d;

    logic wr_vld;
    logic new_req;
    op_t  new_op;
    logic cur_valid;

    // Program-memory builds never see write requests at all.
    assign wr_vld  = mem_write_valid[i] && (WRITE_ENABLE != 0);
    assign new_req = mem_read_valid[i] || wr_vld;
    assign new_op  = mem_read_valid[i] ? OP_READ : OP_WRITE;

    assign chan_req[i]   = ((state_q == IDLE) && new_req) || (state_q == ACCESS);
    assign chan_op[i]    = (state_q == IDLE) ? new_op : op_q;
    assign chan_addr[i]  = (state_q != IDLE)   ? addr_q :
                           mem_read_valid[i]   ? mem_read_address[i] :
                                                 mem_write_address[i];
    assign chan_wdata[i] = (state_q == IDLE) ? mem_write_data[i] : wdata_q;

    // Valid of the operation this channel is completing, watched in DRAIN.
    assign cur_valid = (op_q == OP_READ) ? mem_read_valid[i] : wr_vld;

    always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;
      rready_d = 1'b0;
      wready_d = 1'b0;

      unique case (state_q)
        IDLE: begin
          if (new_req) begin
            op_d    = new_op;
            addr_d  = chan_addr[i];
            wdata_d = mem_write_data[i];
            if (grant[i]) begin
              state_d = DELAY;
              cnt_d   = CNT_INIT;
              if (new_op == OP_READ) rdata_d = mem_rdata;
            end else begin
              state_d = ACCESS;
            end
          end
        end
        ACCESS: begin
          if (grant[i]) begin
            state_d = DELAY;
            cnt_d   = CNT_INIT;
            if (op_q == OP_READ) rdata_d = mem_rdata;
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state_d  = RESP;
            rready_d = (op_q == OP_READ);
            wready_d = (op_q == OP_WRITE);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_d = DRAIN;
        end
        DRAIN: begin
          // Stay until the host drops valid so a held valid is not re-served.
          if (!cur_valid) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= IDLE;
        op_q     <= OP_READ;
        addr_q   <= '0;
        wdata_q  <= '0;
        rdata_q  <= '0;
        cnt_q    <= '0;
        rready_q <= 1'b0;
        wready_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        op_q     <= op_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        rdata_q  <= rdata_d;
        cnt_q    <= cnt_d;
        rready_q <= rready_d;
        wready_q <= wready_d;
      end
    end

    assign mem_read_ready[i]  = rready_q;
    assign mem_read_data[i]   = rdata_q;
    assign mem_write_ready[i] = wready_q;
  end : g_ch

endmodule : mem_channel_responder

// File: tb/tb_mem_channel_responder.sv
// Directed bench for mem_channel_responder (default parameters). Each request
// pushes its expected completion (channel, kind, data, cycle) to a scoreboard;
// ready pulses pop and compare.
module tb_mem_channel_responder;

  localparam int AB  = 8;
  localparam int DB  = 16;
  localparam int NCH = 4;
  localparam int LAT = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NCH-1:0]          mem_read_valid = '0;
  logic [NCH-1:0][AB-1:0]  mem_read_address = '0;
  logic [NCH-1:0]          mem_read_ready;
  logic [NCH-1:0][DB-1:0]  mem_read_data;
  logic [NCH-1:0]          mem_write_valid = '0;
  logic [NCH-1:0][AB-1:0]  mem_write_address = '0;
  logic [NCH-1:0][DB-1:0]  mem_write_data = '0;
  logic [NCH-1:0]          mem_write_ready;
  logic                    load_valid = 1'b0;
  logic [AB-1:0]           load_address = '0;
  logic [DB-1:0]           load_data = '0;

  mem_channel_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NCH), .LATENCY(LAT), .WRITE_ENABLE(1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_read_valid    (mem_read_valid),
    .mem_read_address  (mem_read_address),
    .mem_read_ready    (mem_read_ready),
    .mem_read_data     (mem_read_data),
    .mem_write_valid   (mem_write_valid),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_ready   (mem_write_ready),
    .load_valid        (load_valid),
    .load_address      (load_address),
    .load_data         (load_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    bit          is_wr;
    logic [DB-1:0] data;
    int          cyc;
  } exp_t;

  exp_t          sb_q[$];
  logic [DB-1:0] model_mem [256];
  bit [NCH-1:0]  auto_rel = '1;
  logic [NCH-1:0] prev_rd = '0;
  logic [NCH-1:0] prev_wr = '0;
  int errors = 0;
  int checks = 0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // One ready pulse on channel c: must be single-cycle, expected, on time and
  // (for reads) carry the modelled word.
  task automatic observe(input int c, input bit is_wr, input logic prev_bit);
    int idx;
    idx = -1;
    checks++;
    assert (prev_bit === 1'b0) else begin
      errors++;
      $error("FAIL pulse_width ch%0d wr=%0d: ready high %0d cycles in a row, required 1", c, is_wr, 2);
    end
    for (int k = 0; k < sb_q.size(); k++)
      if (idx < 0 && sb_q[k].ch == c && sb_q[k].is_wr == is_wr) idx = k;
    checks++;
    assert ((idx >= 0) === 1'b1) else begin
      errors++;
      $error("FAIL unexpected_ready ch%0d wr=%0d at cycle %0d: got a pulse, required none", c, is_wr, cyc);
    end
    if (idx >= 0) begin
      checks++;
      assert (cyc === sb_q[idx].cyc) else begin
        errors++;
        $error("FAIL latency ch%0d wr=%0d: ready at cycle %0d, required %0d", c, is_wr, cyc, sb_q[idx].cyc);
      end
      if (!is_wr) begin
        checks++;
        assert (mem_read_data[c] === sb_q[idx].data) else begin
          errors++;
          $error("FAIL read_data ch%0d: got %h, required %h", c, mem_read_data[c], sb_q[idx].data);
        end
      end
      sb_q.delete(idx);
      if (auto_rel[c]) begin
        if (is_wr) mem_write_valid[c] = 1'b0;
        else       mem_read_valid[c]  = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (mem_read_ready[c] === 1'b1)  observe(c, 1'b0, prev_rd[c]);
      if (mem_write_ready[c] === 1'b1) observe(c, 1'b1, prev_wr[c]);
    end
    prev_rd = mem_read_ready;
    prev_wr = mem_write_ready;
  endtask

  // Called at a negedge; the next posedge is E0, so ready is expected on the
  // negedge that follows edge E0+LAT+extra.
  task automatic issue_read(input int c, input logic [AB-1:0] a, input int extra);
    exp_t e;
    mem_read_valid[c]   = 1'b1;
    mem_read_address[c] = a;
    e.ch = c; e.is_wr = 1'b0; e.data = model_mem[a]; e.cyc = cyc + 1 + LAT + extra;
    sb_q.push_back(e);
  endtask

  task automatic issue_write(input int c, input logic [AB-1:0] a, input logic [DB-1:0] d,
                             input int extra);
    exp_t e;
    mem_write_valid[c]   = 1'b1;
    mem_write_address[c] = a;
    mem_write_data[c]    = d;
    model_mem[a]         = d;
    e.ch = c; e.is_wr = 1'b1; e.data = d; e.cyc = cyc + 1 + LAT + extra;
    sb_q.push_back(e);
  endtask

  task automatic preload(input logic [AB-1:0] a, input logic [DB-1:0] d);
    load_valid   = 1'b1;
    load_address = a;
    load_data    = d;
    model_mem[a] = d;
    tick();
    load_valid   = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (sb_q.size() === 0) else begin
      errors++;
      $error("FAIL drain_timeout: %0d completions outstanding after %0d cycles, required 0",
             sb_q.size(), budget);
    end
    sb_q.delete();
    repeat (3) tick();
  endtask

  initial begin
    // Reset state.
    repeat (3) tick();
    checks++;
    assert (mem_read_ready === '0) else begin
      errors++; $error("FAIL reset_read_ready: got %b, required 0", mem_read_ready);
    end
    checks++;
    assert (mem_write_ready === '0) else begin
      errors++; $error("FAIL reset_write_ready: got %b, required 0", mem_write_ready);
    end
    checks++;
    assert (mem_read_data === '0) else begin
      errors++; $error("FAIL reset_read_data: got %h, required 0", mem_read_data);
    end
    reset = 1'b0;
    tick();

    // Preload, then all four channels read at once: pointer 0, order ch0..ch3.
    preload(8'h10, 16'hBEEF);
    preload(8'h11, 16'h1111);
    preload(8'h12, 16'h2222);
    preload(8'h13, 16'h3333);
    for (int c = 0; c < NCH; c++) issue_read(c, AB'(8'h10 + c), c);
    drain(20);

    // Single uncontended read of the preloaded word; pointer moves to 1.
    issue_read(0, 8'h10, 0);
    drain(10);

    // Second simultaneous round starts at the pointer: ch1, ch2, ch3, ch0.
    issue_read(1, 8'h11, 0);
    issue_read(2, 8'h12, 1);
    issue_read(3, 8'h13, 2);
    issue_read(0, 8'h10, 3);
    drain(20);

    // ch1 writes 0x20, ch2 reads 0x20 one cycle later and sees the new word.
    issue_write(1, 8'h20, 16'h1234, 0);
    tick();
    issue_read(2, 8'h20, 0);
    drain(10);

    // Valid held 3 cycles past ready: exactly one pulse, no re-issue.
    auto_rel[0] = 1'b0;
    issue_read(0, 8'h10, 0);
    drain(10);
    for (int k = 0; k < 3; k++) begin
      checks++;
      assert (mem_read_ready[0] === 1'b0) else begin
        errors++; $error("FAIL held_valid_reissue: ready[0]=%b, required 0", mem_read_ready[0]);
      end
      tick();
    end
    mem_read_valid[0] = 1'b0;
    tick();
    auto_rel[0] = 1'b1;
    issue_read(0, 8'h11, 0);
    drain(10);

    // Four back-to-back loads to the address ch0 is reading: 4-cycle delay and
    // the last loaded word is returned.
    load_valid   = 1'b1;
    load_address = 8'h30;
    model_mem[8'h30] = 16'hA003;
    issue_read(0, 8'h30, 4);
    for (int k = 0; k < 4; k++) begin
      load_data = DB'(16'hA000 + k);
      tick();
    end
    load_valid = 1'b0;
    drain(10);

    // Load then channel write to the same address: the write lands later and wins.
    load_valid   = 1'b1;
    load_address = 8'h40;
    load_data    = 16'h1111;
    issue_write(1, 8'h40, 16'h2222, 1);
    tick();
    load_valid = 1'b0;
    drain(10);
    issue_read(2, 8'h40, 0);
    drain(10);

    // Reset while ch3 is in DELAY: no ready, outputs cleared, storage kept.
    mem_read_valid[3]   = 1'b1;
    mem_read_address[3] = 8'h12;
    tick();
    reset = 1'b1;
    tick();
    mem_read_valid[3] = 1'b0;
    tick();
    checks++;
    assert (mem_read_ready === '0) else begin
      errors++; $error("FAIL reset_mid_ready: got %b, required 0", mem_read_ready);
    end
    checks++;
    assert (mem_read_data === '0) else begin
      errors++; $error("FAIL reset_mid_data: got %h, required 0", mem_read_data);
    end
    reset = 1'b0;
    repeat (5) tick();

    // Pointer restarts at 0; preload and earlier channel write both survived.
    issue_read(3, 8'h10, 1);
    issue_read(0, 8'h20, 0);
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_channel_responder
